booth_mul_arbiter: RTL and testbench
====================================

// Module: booth_mul_arbiter
// PURPOSE
//  Shares one sequential radix-2 Booth multiplier core between NREQ requesters.
//  Round-robin arbitration, per-requester req/done handshake, and core sequencing (load, WIDTH iterations, unload).
//  Sits between client FSMs and the multiplier datapath; it is the only block that starts the core.
// PARAMETERS
//  NREQ   4  number of requesters (2..8)
//  WIDTH  4  operand width, signed two's complement (product is 2*WIDTH)
// PORTS
//  clock         in   1              single system clock, rising edge
//  reset_n       in   1              asynchronous, active-low reset
//  req           in   NREQ           request per client; held high until its done pulse
//  mcand_flat    in   NREQ*WIDTH     multiplicand of client i at [i*WIDTH +: WIDTH]
//  mplier_flat   in   NREQ*WIDTH     multiplier of client i at [i*WIDTH +: WIDTH]
//  grant         out  NREQ           one-hot; client currently owning the core
//  done          out  NREQ           one-cycle pulse to the served client; product valid that cycle
//  product       out  2*WIDTH        signed result of the last completed operation
//  busy          out  1              high in every state except IDLE
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, grant=0, done=0, product=0, busy=0, rr pointer=0.
//  FSM: IDLE -> LOAD -> RUN -> DONE -> IDLE.
//   IDLE: sample req. If req!=0, grant the first set bit at or above rr_ptr, wrapping modulo NREQ. Go to LOAD.
//   LOAD: latch operands of the granted client into the core; P={0,mplier,0}; iteration count=0.
//   RUN: one Booth step per cycle. P[1:0]=01 adds M, 10 subtracts M, 00/11 does nothing. Then an arithmetic right shift by 1.
//    After exactly WIDTH steps, go to DONE.
//   DONE: product<=P[2*WIDTH:1]; done[g]=1 for this cycle only; rr_ptr<=(g+1) mod NREQ; grant<=0. Go to IDLE.
//  Latency: done rises WIDTH+2 edges after the IDLE sampling edge (6 for WIDTH=4).
//   Throughput: one operation per WIDTH+3 cycles.
//  Width rule: M is sign-extended to WIDTH+1 bits, and P is 2*WIDTH+2 bits wide.
//   This keeps (-2^(W-1))*(-2^(W-1)) correct (-8*-8=+64, no overflow).
//  Operands are sampled only in LOAD. Changes to the inputs after LOAD do not affect the result.
//  req drop after grant: the operation still completes and done still pulses; the client ignores it.
//  req drop before the IDLE sample: the client is not served and there is no side effect.
//  req still high in the done cycle: the client re-enters arbitration as lowest priority (rr_ptr has advanced).
//  Simultaneous requests: exactly one grant. The others wait, with no starvation (bounded by NREQ ops).
//  product holds its value until the next DONE. It is not cleared on IDLE.
//  Reset mid-operation (any state): immediate return to reset values. No done pulse, and the partial result is lost.
//  grant, done and busy are registered outputs (no combinational path from req).
// STRUCTURE
//  Shared package (booth_pkg): FSM state encodings (IDLE/LOAD/RUN/DONE), Booth pair codes (2'b01 ADD, 2'b10 SUB),
//  and a round-robin pick function (req, ptr) -> one-hot.
//  Sub-module booth_mul_core (clock, reset_n, load, step, mcand, mplier, p_out).
//  It is a purely synchronous iterative datapath with no start-edge sensitivity; the arbiter drives load/step.
//  The top level holds the FSM, the iteration counter, rr_ptr, the grant register and the output mux.
// TESTING
//  1. req=0001, c0: 3 x -2 -> done[0] 6 cycles after the sample edge, product=8'hFA, grant=0001 during the op.
//  2. req=0001, c0: -8 x -8 -> product=8'h40; then 7 x -8 -> product=8'hC8.
//  3. req=1111 held, ops 1x1, 2x2, 3x3, 4x4 -> done order c0,c1,c2,c3, products 1,4,9,16, each 7 cycles apart.
//  4. After serving c2, assert req=1010 together -> c3 served first, then c1 (rr wrap).
//  5. Assert reset_n=0 in the 2nd RUN cycle of 5x5 -> outputs zero immediately, no done pulse.
//     After release, req=0001 2x3 -> product=6.
//  6. Change mcand_flat during RUN for the granted client -> result reflects the LOAD-time value.
//     Dropping req mid-RUN -> done still pulses once.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared FSM encodings, Booth recoding pairs and the round-robin picker
// used by the Booth multiplier arbiter and its datapath core.
package booth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

    localparam int unsigned RR_MAX = 8;

    // First set request at or above ptr, wrapping modulo nreq; result is one-hot.
    function automatic logic [RR_MAX-1:0] rr_pick(input logic [RR_MAX-1:0] req,
                                                  input int unsigned       ptr,
                                                  input int unsigned       nreq);
        logic [RR_MAX-1:0] pick;
        logic              found;
        int unsigned       idx;
        pick  = {RR_MAX{1'b0}};
        found = 1'b0;
        for (int unsigned i = 0; i < RR_MAX; i++) begin
            idx = (ptr + i) % nreq;
            if (!found && (i < nreq) && req[idx[2:0]]) begin
                pick[idx[2:0]] = 1'b1;
                found          = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/booth_mul_arbiter_if.sv
// Client-side bus of the shared Booth multiplier: per-client requests and
// operands in, grant/done/product/busy back out.
interface booth_mul_arbiter_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 4
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] mcand_flat;
    logic [NREQ*WIDTH-1:0] mplier_flat;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       done;
    logic [2*WIDTH-1:0]    product;
    logic                  busy;

    modport master (
        output req, mcand_flat, mplier_flat,
        input  grant, done, product, busy
    );

    modport slave (
        input  req, mcand_flat, mplier_flat,
        output grant, done, product, busy
    );
endinterface

// File: rtl/booth_mul_core.sv
// Iterative radix-2 Booth datapath: load latches operands, each step does one
// recode/add/shift. Sequencing is entirely up to whoever drives load/step.
module booth_mul_core
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic [2*WIDTH-1:0] p_out
);

    localparam int unsigned PW = 2 * WIDTH + 2;

    // Multiplicand carries one guard bit so the most negative operand squares without overflow.
    logic [WIDTH:0]  m_r;
    logic [PW-1:0]   p_r;
    logic [PW-1:0]   p_step_s;
    logic [WIDTH:0]  acc_s;

    // One Booth iteration: recode the low pair, add/subtract M, arithmetic shift right.
    always_comb begin
        acc_s = p_r[PW-1:WIDTH+1];
        case (p_r[1:0])
            BOOTH_ADD: acc_s = p_r[PW-1:WIDTH+1] + m_r;
            BOOTH_SUB: acc_s = p_r[PW-1:WIDTH+1] - m_r;
            default:   acc_s = p_r[PW-1:WIDTH+1];
        endcase
        p_step_s = {acc_s[WIDTH], acc_s, p_r[WIDTH:1]};
    end

    // Operand/partial-product registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_r <= {(WIDTH+1){1'b0}};
            p_r <= {PW{1'b0}};
        end else if (load) begin
            m_r <= {mcand[WIDTH-1], mcand};
            p_r <= {{(WIDTH+1){1'b0}}, mplier, 1'b0};
        end else if (step) begin
            m_r <= m_r;
            p_r <= p_step_s;
        end else begin
            m_r <= m_r;
            p_r <= p_r;
        end
    end

    assign p_out = p_r[2*WIDTH:1];

endmodule

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter that owns the shared Booth core: picks a client, loads
// its operands, runs WIDTH steps and returns the product with a done pulse.
module booth_mul_arbiter
    import booth_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 4
) (
    input logic                clock,
    input logic                reset_n,
    booth_mul_arbiter_if.slave bus
);

    localparam int unsigned PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CNTW = $clog2(WIDTH + 1);

    localparam logic [PTRW-1:0] PTR_ONE  = PTRW'(1);
    localparam logic [PTRW-1:0] PTR_LAST = PTRW'(NREQ - 1);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);

    state_t             state_r, state_nxt_s;
    logic [NREQ-1:0]    grant_r, grant_nxt_s;
    logic [NREQ-1:0]    done_r, done_nxt_s;
    logic [2*WIDTH-1:0] product_r, product_nxt_s;
    logic               busy_r, busy_nxt_s;
    logic [PTRW-1:0]    rr_ptr_r, rr_nxt_s;
    logic [CNTW-1:0]    cnt_r, cnt_nxt_s;

    logic [RR_MAX-1:0]  req_ext_s;
    logic [RR_MAX-1:0]  pick_full_s;
    logic [PTRW-1:0]    gidx_s;
    logic [WIDTH-1:0]   mcand_s;
    logic [WIDTH-1:0]   mplier_s;
    logic               load_s;
    logic               step_s;
    logic [2*WIDTH-1:0] p_s;

    // Widen the request vector to the picker's fixed width and arbitrate.
    always_comb begin
        req_ext_s             = {RR_MAX{1'b0}};
        req_ext_s[NREQ-1:0]   = bus.req;
        pick_full_s           = rr_pick(req_ext_s, 32'(rr_ptr_r), NREQ);
    end

    // Encode the granted client and route its operands to the core.
    always_comb begin
        gidx_s   = {PTRW{1'b0}};
        mcand_s  = {WIDTH{1'b0}};
        mplier_s = {WIDTH{1'b0}};
        for (int i = 0; i < int'(NREQ); i++) begin
            if (grant_r[i]) begin
                gidx_s   = PTRW'(i);
                mcand_s  = bus.mcand_flat[i*WIDTH +: WIDTH];
                mplier_s = bus.mplier_flat[i*WIDTH +: WIDTH];
            end else begin
                gidx_s = gidx_s;
            end
        end
    end

    booth_mul_core #(.WIDTH(WIDTH)) u_core (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (load_s),
        .step    (step_s),
        .mcand   (mcand_s),
        .mplier  (mplier_s),
        .p_out   (p_s)
    );

    // Sequencer next-state and next-output logic.
    always_comb begin
        state_nxt_s   = state_r;
        grant_nxt_s   = grant_r;
        done_nxt_s    = {NREQ{1'b0}};
        product_nxt_s = product_r;
        rr_nxt_s      = rr_ptr_r;
        cnt_nxt_s     = cnt_r;
        load_s        = 1'b0;
        step_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (|pick_full_s) begin
                    grant_nxt_s = pick_full_s[NREQ-1:0];
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                load_s      = 1'b1;
                cnt_nxt_s   = {CNTW{1'b0}};
                state_nxt_s = ST_RUN;
            end
            ST_RUN: begin
                step_s    = 1'b1;
                cnt_nxt_s = cnt_r + CNT_ONE;
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                product_nxt_s = p_s;
                done_nxt_s    = grant_r;
                grant_nxt_s   = {NREQ{1'b0}};
                rr_nxt_s      = (gidx_s == PTR_LAST) ? {PTRW{1'b0}} : (gidx_s + PTR_ONE);
                state_nxt_s   = ST_IDLE;
            end
            default: begin
                grant_nxt_s = {NREQ{1'b0}};
                state_nxt_s = ST_IDLE;
            end
        endcase
        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            grant_r   <= {NREQ{1'b0}};
            done_r    <= {NREQ{1'b0}};
            product_r <= {(2*WIDTH){1'b0}};
            busy_r    <= 1'b0;
            rr_ptr_r  <= {PTRW{1'b0}};
            cnt_r     <= {CNTW{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            grant_r   <= grant_nxt_s;
            done_r    <= done_nxt_s;
            product_r <= product_nxt_s;
            busy_r    <= busy_nxt_s;
            rr_ptr_r  <= rr_nxt_s;
            cnt_r     <= cnt_nxt_s;
        end
    end

    assign bus.grant   = grant_r;
    assign bus.done    = done_r;
    assign bus.product = product_r;
    assign bus.busy    = busy_r;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed scoreboard bench for booth_mul_arbiter: expected products and
// serving order are queued when requests are raised and checked on done.
module tb_booth_mul_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 4;
    localparam int unsigned PW    = 2 * WIDTH;

    typedef struct {
        logic [NREQ-1:0] done;
        logic [PW-1:0]   product;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;

    booth_mul_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    booth_mul_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Set a client's operands, raise its request and queue the expected result.
    task automatic push_op(input int c, input logic signed [WIDTH-1:0] a,
                           input logic signed [WIDTH-1:0] b);
        exp_t                  e;
        logic signed [PW-1:0]  prod;
        bus.mcand_flat[c*WIDTH +: WIDTH]  = a;
        bus.mplier_flat[c*WIDTH +: WIDTH] = b;
        prod      = PW'(a) * PW'(b);
        e.done    = {NREQ{1'b0}};
        e.done[c] = 1'b1;
        e.product = prod;
        sb_q.push_back(e);
        bus.req[c] = 1'b1;
    endtask

    // Wait for the next done, compare against the queue head; optional mid-run tamper.
    task automatic serve(input int tamper_edge, input int tc);
        exp_t e;
        int   n;
        bit   seen;
        e    = sb_q.pop_front();
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 20) begin
            n++;
            tick();
            if (n == 1) begin
                check("grant_onehot", 32'(bus.grant), 32'(e.done));
                check("busy_during_op", 32'(bus.busy), 32'(1));
            end
            if (n == tamper_edge) begin
                bus.mcand_flat[tc*WIDTH +: WIDTH] = ~bus.mcand_flat[tc*WIDTH +: WIDTH];
                bus.req[tc] = 1'b0;
            end
            if (bus.done != {NREQ{1'b0}}) begin
                seen = 1'b1;
                check("latency", 32'(n - 1), 32'(WIDTH + 2));
                check("done_client", 32'(bus.done), 32'(e.done));
                check("product", 32'(bus.product), 32'(e.product));
                check("grant_released", 32'(bus.grant), 32'(0));
                for (int i = 0; i < int'(NREQ); i++) begin
                    if (e.done[i]) bus.req[i] = 1'b0;
                end
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout observed=no done expected=done for %0h", e.done);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("rst_grant", 32'(bus.grant), 32'(0));
        check("rst_done", 32'(bus.done), 32'(0));
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_product", 32'(bus.product), 32'(0));
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [NREQ-1:0] seen_done;
        bus.req         = {NREQ{1'b0}};
        bus.mcand_flat  = {(NREQ*WIDTH){1'b0}};
        bus.mplier_flat = {(NREQ*WIDTH){1'b0}};
        #2;
        do_reset();

        // 3 x -2 on client 0, then done must be a single-cycle pulse
        push_op(0, 4'sd3, -4'sd2);
        serve(0, 0);
        tick();
        check("done_one_cycle", 32'(bus.done), 32'(0));
        check("product_holds", 32'(bus.product), 32'(8'hFA));
        check("idle_not_busy", 32'(bus.busy), 32'(0));

        // Most-negative squared, then 7 x -8
        push_op(0, 4'sb1000, 4'sb1000);
        serve(0, 0);
        push_op(0, 4'sd7, 4'sb1000);
        serve(0, 0);

        // Fresh pointer, all four clients at once: served in order c0..c3
        do_reset();
        push_op(0, 4'sd1, 4'sd1);
        push_op(1, 4'sd2, 4'sd2);
        push_op(2, 4'sd3, 4'sd3);
        push_op(3, 4'sd4, 4'sd4);
        repeat (4) serve(0, 0);

        // Pointer wrap: after c2, c3 beats c1
        push_op(2, -4'sd3, 4'sd5);
        serve(0, 0);
        push_op(3, -4'sd7, 4'sd6);
        push_op(1, 4'sd6, -4'sd5);
        serve(0, 0);
        serve(0, 0);

        // Reset in the second RUN cycle aborts without a done pulse
        bus.mcand_flat[3:0]  = 4'd5;
        bus.mplier_flat[3:0] = 4'd5;
        bus.req              = 4'b0001;
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        check("abort_grant", 32'(bus.grant), 32'(0));
        check("abort_busy", 32'(bus.busy), 32'(0));
        check("abort_product", 32'(bus.product), 32'(0));
        bus.req   = {NREQ{1'b0}};
        seen_done = {NREQ{1'b0}};
        repeat (4) begin
            tick();
            seen_done = seen_done | bus.done;
        end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (6) begin
            tick();
            seen_done = seen_done | bus.done;
        end
        check("abort_no_done", 32'(seen_done), 32'(0));
        push_op(0, 4'sd2, 4'sd3);
        serve(0, 0);

        // Operands tampered and req dropped mid-RUN: LOAD-time result, one done
        push_op(2, 4'sd7, 4'sd3);
        serve(3, 2);
        seen_done = {NREQ{1'b0}};
        repeat (8) begin
            tick();
            seen_done = seen_done | bus.done;
        end
        check("no_repeat_done", 32'(seen_done), 32'(0));
        check("final_product", 32'(bus.product), 32'(8'h15));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
